ct_fcnvt_wb_buf: RTL and testbench
==================================

# ct_fcnvt_wb_buf

Writeback buffer and fflags accumulator directly downstream of the FP convert unit. Captures each EX3 forward result and its exception flags, holds up to two results in a FIFO until the vector/FP register writeback arbiter grants the port, and ORs the flags of every retired result into a sticky 5-bit fflags accumulator. Raises `fcnvt_wb_full` so issue control can stop sending convert ops, and records any dropped result in a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 2, FIFO entries (fixed; pointers 1 bit, count 2 bits)
- PREG_W, 7, destination physical-register tag width

Ports:
- forever_cpuclk  in  1  clock; all state on rising edge
- cpurst  in  1  reset; **asynchronous, active-high**
- fcnvt_forward_r_vld  in  1  EX3 result valid
- fcnvt_forward_result  in  64  EX3 result data
- fcnvt_ereg_forward_r_vld  in  1  EX3 exception-flag valid
- fcnvt_ereg_forward_result  in  5  flags {NV,DZ,OF,UF,NX}
- dp_fcnvt_ex3_preg  in  PREG_W  destination tag, qualified by fcnvt_forward_r_vld
- wb_fcnvt_grant  in  1  arbiter accepts head entry this cycle
- cp0_fflags_clr  in  1  one-cycle clear of accumulator
- fcnvt_wb_vld  out  1  head entry valid
- fcnvt_wb_data  out  64  head data
- fcnvt_wb_preg  out  PREG_W  head tag
- fcnvt_wb_expt  out  5  head flags
- fcnvt_wb_full  out  1  count == 2
- fcnvt_fflags  out  5  sticky accumulated flags
- fcnvt_wb_ovf  out  1  sticky: result dropped

## Operation
- Entry = {data[63:0], preg, expt[4:0]}; expt = fcnvt_ereg_forward_result when fcnvt_ereg_forward_r_vld, else 5'b0.
- push = fcnvt_forward_r_vld & (count<2 | pop); pop = fcnvt_wb_vld & wb_fcnvt_grant.
- Write at wptr, read at rptr; pointers wrap 1->0. count += push - pop.
- Head outputs driven from registered storage at rptr; fcnvt_wb_data/preg/expt are don't-care when fcnvt_wb_vld=0 but must not X-propagate (storage reset to 0).
- Push when full with no pop: result dropped, pointers/count unchanged, fcnvt_wb_ovf set (sticky until reset).
- Push and pop same cycle at count 2: both happen, count stays 2; at count 1: count stays 1; at count 0: no pop possible (no bypass), count -> 1.
- fflags next = (cp0_fflags_clr ? 0 : fcnvt_fflags) | (pop ? head expt : 0) | orphan, where orphan = fcnvt_ereg_forward_result when fcnvt_ereg_forward_r_vld & !fcnvt_forward_r_vld (flag-only op, OR'd directly, never enqueued). Clear and accumulate in same cycle: new flags survive.
- wb_fcnvt_grant with fcnvt_wb_vld=0: ignored.

## Timing
- Reset (cpurst high, async): count=0, wptr=rptr=0, storage=0, fcnvt_wb_vld=0, fcnvt_wb_full=0, fcnvt_fflags=0, fcnvt_wb_ovf=0. Deassertion mid-stream: contents lost, first push after release is entry 0.
- Latency: push at edge N -> fcnvt_wb_vld=1 in cycle N+1 with that entry at head. Minimum residency 1 cycle.
- Grant at cycle M pops at edge M; next entry (if any) visible cycle M+1.
- fcnvt_wb_full and fcnvt_wb_vld are registered-state decodes (count), no combinational path from inputs.
- fflags update visible the cycle after the pop/orphan/clear.
- Throughput: 1 result/cycle sustained when grant held high.

## Test plan
- Single push: r_vld=1, data=64'h3FF0_0000_0000_0000, preg=5, ereg vld flags=5'b00001, grant=1 -> cycle+1 wb_vld=1, data/preg/expt match; cycle+2 wb_vld=0, fflags=5'b00001.
- Fill and overflow: grant=0, three consecutive pushes A,B,C -> full=1 after 2, C dropped, ovf=1; then grant=1 -> A then B popped in order, wb_vld=0 after, ovf stays 1.
- Full with simultaneous push/pop: count 2, grant=1 and push D -> A popped, D enqueued, full stays 1, order B,D, ovf unchanged.
- Flag accumulation/clear: pop entries with flags 5'b10000 then 5'b00100 -> fflags=5'b10100; assert cp0_fflags_clr same cycle as pop with 5'b00010 -> fflags=5'b00010.
- Orphan flags: ereg vld=1 flags 5'b01000 with r_vld=0 -> no enqueue, count unchanged, fflags gains 5'b01000 next cycle.
- Async reset mid-operation: count 2, fflags nonzero, assert cpurst between edges -> outputs zero immediately; after release, push E -> E is first wb head one cycle later.

Source files
------------

// File: rtl/ct_fcnvt_wb_buf.sv
// ct_fcnvt_wb_buf: two-entry writeback FIFO behind the FP convert unit with
// a sticky fflags accumulator and sticky overflow flag.
module ct_fcnvt_wb_buf #(
    parameter int DEPTH  = 2,
    parameter int PREG_W = 7
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              fcnvt_forward_r_vld,
    input  logic [63:0]       fcnvt_forward_result,
    input  logic              fcnvt_ereg_forward_r_vld,
    input  logic [4:0]        fcnvt_ereg_forward_result,
    input  logic [PREG_W-1:0] dp_fcnvt_ex3_preg,
    input  logic              wb_fcnvt_grant,
    input  logic              cp0_fflags_clr,
    output logic              fcnvt_wb_vld,
    output logic [63:0]       fcnvt_wb_data,
    output logic [PREG_W-1:0] fcnvt_wb_preg,
    output logic [4:0]        fcnvt_wb_expt,
    output logic              fcnvt_wb_full,
    output logic [4:0]        fcnvt_fflags,
    output logic              fcnvt_wb_ovf
);
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [63:0]       data_q [2];
    logic [PREG_W-1:0] preg_q [2];
    logic [4:0]        expt_q [2];
    logic              wptr_q, rptr_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [4:0]        fflags_q, fflags_d, expt_in, orphan;
    logic              ovf_q, push, pop;

    assign fcnvt_wb_vld  = cnt_q != 2'd0;
    assign fcnvt_wb_full = cnt_q == FULL_CNT;
    assign fcnvt_wb_data = data_q[rptr_q];
    assign fcnvt_wb_preg = preg_q[rptr_q];
    assign fcnvt_wb_expt = expt_q[rptr_q];
    assign fcnvt_fflags  = fflags_q;
    assign fcnvt_wb_ovf  = ovf_q;

    always_comb begin
        pop      = fcnvt_wb_vld & wb_fcnvt_grant;
        push     = fcnvt_forward_r_vld & (~fcnvt_wb_full | pop);
        cnt_d    = 2'(cnt_q + {1'b0, push} - {1'b0, pop});
        expt_in  = fcnvt_ereg_forward_r_vld ? fcnvt_ereg_forward_result : 5'b0;
        // Flag-only ops never occupy an entry; their flags go straight to the accumulator.
        orphan   = (fcnvt_ereg_forward_r_vld & ~fcnvt_forward_r_vld) ? fcnvt_ereg_forward_result : 5'b0;
        fflags_d = (cp0_fflags_clr ? 5'b0 : fflags_q) | (pop ? fcnvt_wb_expt : 5'b0) | orphan;
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                preg_q[i] <= '0;
                expt_q[i] <= '0;
            end
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
            fflags_q <= 5'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                data_q[wptr_q] <= fcnvt_forward_result;
                preg_q[wptr_q] <= dp_fcnvt_ex3_preg;
                expt_q[wptr_q] <= expt_in;
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
            if (fcnvt_forward_r_vld & ~push) ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ct_fcnvt_wb_buf.sv
// tb_ct_fcnvt_wb_buf: directed scenario bench for the convert writeback buffer.
module tb_ct_fcnvt_wb_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_vld, ereg_vld, grant, clr;
    logic [63:0] fwd_data;
    logic [4:0]  ereg_flags;
    logic [6:0]  preg;
    logic        wb_vld, wb_full, wb_ovf;
    logic [63:0] wb_data;
    logic [6:0]  wb_preg;
    logic [4:0]  wb_expt, fflags;
    int          n = 0;
    int          p = 0;

    ct_fcnvt_wb_buf #(.DEPTH(2), .PREG_W(7)) dut (
        .forever_cpuclk(clk), .cpurst(rst),
        .fcnvt_forward_r_vld(fwd_vld), .fcnvt_forward_result(fwd_data),
        .fcnvt_ereg_forward_r_vld(ereg_vld), .fcnvt_ereg_forward_result(ereg_flags),
        .dp_fcnvt_ex3_preg(preg), .wb_fcnvt_grant(grant), .cp0_fflags_clr(clr),
        .fcnvt_wb_vld(wb_vld), .fcnvt_wb_data(wb_data), .fcnvt_wb_preg(wb_preg),
        .fcnvt_wb_expt(wb_expt), .fcnvt_wb_full(wb_full), .fcnvt_fflags(fflags),
        .fcnvt_wb_ovf(wb_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [6:0] pr,
                         input logic ev, input logic [4:0] f);
        fwd_vld = v; fwd_data = d; preg = pr; ereg_vld = ev; ereg_flags = f;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; grant = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick();
        n++; if (wb_vld !== 1'b0) $display("FAIL reset_vld got %b exp 0", wb_vld); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL reset_full got %b exp 0", wb_full); else p++;
        n++; if (fflags !== 5'b0) $display("FAIL reset_fflags got %b exp 00000", fflags); else p++;
        n++; if (wb_ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", wb_ovf); else p++;
        n++; if (wb_data !== 64'h0) $display("FAIL reset_data got %h exp 0", wb_data); else p++;
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        grant = 1'b1;
        drive(1'b1, 64'h3FF0_0000_0000_0000, 7'd5, 1'b1, 5'b00001);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (wb_vld !== 1'b1) $display("FAIL single_vld got %b exp 1", wb_vld); else p++;
        n++; if (wb_data !== 64'h3FF0_0000_0000_0000) $display("FAIL single_data got %h exp 3ff0000000000000", wb_data); else p++;
        n++; if (wb_preg !== 7'd5) $display("FAIL single_preg got %0d exp 5", wb_preg); else p++;
        n++; if (wb_expt !== 5'b00001) $display("FAIL single_expt got %b exp 00001", wb_expt); else p++;
        n++; if (fflags !== 5'b0) $display("FAIL single_fflags_early got %b exp 00000", fflags); else p++;
        tick();
        n++; if (wb_vld !== 1'b0) $display("FAIL single_drain got %b exp 0", wb_vld); else p++;
        n++; if (fflags !== 5'b00001) $display("FAIL single_fflags got %b exp 00001", fflags); else p++;
        grant = 1'b0;
    endtask

    task automatic test_fill_overflow();
        grant = 1'b0;
        drive(1'b1, 64'hAAAA_0000_0000_000A, 7'd10, 1'b1, 5'b10000); tick();
        drive(1'b1, 64'hBBBB_0000_0000_000B, 7'd11, 1'b1, 5'b00100); tick();
        n++; if (wb_full !== 1'b1) $display("FAIL fill_full got %b exp 1", wb_full); else p++;
        n++; if (wb_ovf !== 1'b0) $display("FAIL fill_ovf_early got %b exp 0", wb_ovf); else p++;
        drive(1'b1, 64'hCCCC_0000_0000_000C, 7'd12, 1'b0, 5'b0); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (wb_ovf !== 1'b1) $display("FAIL fill_ovf got %b exp 1", wb_ovf); else p++;
        n++; if (wb_data !== 64'hAAAA_0000_0000_000A) $display("FAIL fill_head_a got %h exp aaaa00000000000a", wb_data); else p++;
        n++; if (wb_preg !== 7'd10) $display("FAIL fill_preg_a got %0d exp 10", wb_preg); else p++;
        grant = 1'b1; tick();
        n++; if (wb_data !== 64'hBBBB_0000_0000_000B) $display("FAIL fill_head_b got %h exp bbbb00000000000b", wb_data); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL fill_unfull got %b exp 0", wb_full); else p++;
        n++; if (fflags !== 5'b10001) $display("FAIL fill_fflags_a got %b exp 10001", fflags); else p++;
        tick();
        n++; if (wb_vld !== 1'b0) $display("FAIL fill_empty got %b exp 0", wb_vld); else p++;
        n++; if (wb_ovf !== 1'b1) $display("FAIL fill_ovf_sticky got %b exp 1", wb_ovf); else p++;
        n++; if (fflags !== 5'b10101) $display("FAIL fill_fflags_b got %b exp 10101", fflags); else p++;
        tick();
        n++; if (wb_vld !== 1'b0) $display("FAIL idle_grant_vld got %b exp 0", wb_vld); else p++;
        grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        grant = 1'b0;
        drive(1'b1, 64'h0000_0000_0000_00A2, 7'd20, 1'b0, 5'b0); tick();
        drive(1'b1, 64'h0000_0000_0000_00B2, 7'd21, 1'b0, 5'b0); tick();
        grant = 1'b1;
        drive(1'b1, 64'h0000_0000_0000_00D0, 7'd22, 1'b0, 5'b0); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (wb_full !== 1'b1) $display("FAIL b2b_full got %b exp 1", wb_full); else p++;
        n++; if (wb_data !== 64'hB2) $display("FAIL b2b_head_b got %h exp b2", wb_data); else p++;
        tick();
        n++; if (wb_data !== 64'hD0) $display("FAIL b2b_head_d got %h exp d0", wb_data); else p++;
        n++; if (wb_preg !== 7'd22) $display("FAIL b2b_preg_d got %0d exp 22", wb_preg); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL b2b_unfull got %b exp 0", wb_full); else p++;
        tick();
        n++; if (wb_vld !== 1'b0) $display("FAIL b2b_empty got %b exp 0", wb_vld); else p++;
        n++; if (wb_ovf !== 1'b1) $display("FAIL b2b_ovf got %b exp 1", wb_ovf); else p++;
        n++; if (fflags !== 5'b10101) $display("FAIL b2b_fflags got %b exp 10101", fflags); else p++;
        grant = 1'b0;
    endtask

    task automatic test_flags_clear();
        drive(1'b1, 64'h55, 7'd30, 1'b1, 5'b00010); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        clr = 1'b1; grant = 1'b1; tick();
        clr = 1'b0; grant = 1'b0;
        n++; if (fflags !== 5'b00010) $display("FAIL clr_fflags got %b exp 00010", fflags); else p++;
        n++; if (wb_vld !== 1'b0) $display("FAIL clr_empty got %b exp 0", wb_vld); else p++;
    endtask

    task automatic test_orphan();
        drive(1'b1, 64'hF0F0, 7'd40, 1'b0, 5'b0); tick();
        drive(1'b0, '0, '0, 1'b1, 5'b01000); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (fflags !== 5'b01010) $display("FAIL orphan_fflags got %b exp 01010", fflags); else p++;
        n++; if (wb_vld !== 1'b1) $display("FAIL orphan_vld got %b exp 1", wb_vld); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL orphan_full got %b exp 0", wb_full); else p++;
        n++; if (wb_expt !== 5'b0) $display("FAIL orphan_expt got %b exp 00000", wb_expt); else p++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 64'h6060, 7'd41, 1'b0, 5'b0); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (wb_full !== 1'b1) $display("FAIL arst_pre_full got %b exp 1", wb_full); else p++;
        #2 rst = 1'b1;
        #1;
        n++; if (wb_vld !== 1'b0) $display("FAIL arst_vld got %b exp 0", wb_vld); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL arst_full got %b exp 0", wb_full); else p++;
        n++; if (fflags !== 5'b0) $display("FAIL arst_fflags got %b exp 00000", fflags); else p++;
        n++; if (wb_ovf !== 1'b0) $display("FAIL arst_ovf got %b exp 0", wb_ovf); else p++;
        @(negedge clk); rst = 1'b0;
        tick();
        drive(1'b1, 64'hEEEE_EEEE_0000_0001, 7'd50, 1'b1, 5'b00100); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        n++; if (wb_vld !== 1'b1) $display("FAIL arst_e_vld got %b exp 1", wb_vld); else p++;
        n++; if (wb_data !== 64'hEEEE_EEEE_0000_0001) $display("FAIL arst_e_data got %h exp eeeeeeee00000001", wb_data); else p++;
        n++; if (wb_preg !== 7'd50) $display("FAIL arst_e_preg got %0d exp 50", wb_preg); else p++;
        n++; if (wb_full !== 1'b0) $display("FAIL arst_e_full got %b exp 0", wb_full); else p++;
        grant = 1'b1; tick(); grant = 1'b0;
        n++; if (wb_vld !== 1'b0) $display("FAIL arst_e_pop got %b exp 0", wb_vld); else p++;
        n++; if (fflags !== 5'b00100) $display("FAIL arst_e_fflags got %b exp 00100", fflags); else p++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_back_to_back();
        test_flags_clear();
        test_orphan();
        test_async_reset();
        $display("%0d/%0d checks passed", p, n);
        $finish;
    end
endmodule
